topk_tracker: RTL
=================

# topk_tracker

Streaming top-K tracker: keeps the DEPTH largest values seen on a valid-qualified input stream, as a sorted register array. Any rank can be read back. This is the parametrised successor of the team's fixed second-largest tracker. It adds configurable depth, an input valid qualifier, per-slot occupancy, a synchronous clear, and an optional duplicate-suppression mode. It sits on the datapath monitoring stream (statistics / peak capture) and is read by control logic.

## Interface
- DATA_WIDTH, 32, width of each sample, unsigned.
- DEPTH, 4, number of tracked ranks K; legal range 2..64.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; dominates every other input.
- din_valid  input  1  din is a sample this cycle.
- din  input  DATA_WIDTH  sample value.
- clear  input  1  synchronous flush of all ranks.
- rd_idx  input  $clog2(DEPTH)  rank to read; 0 is the largest.
- dout  output  DATA_WIDTH  value at rank rd_idx; 0 if that slot is empty or rd_idx >= DEPTH.
- dout_valid  output  1  slot rd_idx is occupied.
- count  output  $clog2(DEPTH+1)  number of occupied slots; saturates at DEPTH.
- full  output  1  count == DEPTH.

## Operation
- State: val[0..DEPTH-1] (DATA_WIDTH each) plus occ[0..DEPTH-1]. The array is sorted descending, and the occupied slots are a contiguous prefix 0..count-1.
- Reset: all occ = 0, all val = 0. Therefore count = 0, full = 0, dout = 0, dout_valid = 0.
- Insert (din_valid = 1, clear = 0):
  - Position p = lowest i where occ[i] = 0 or din >= val[i]. Ties place the new sample above the existing equal entries.
  - If p exists: slots p..DEPTH-2 shift down one place, slot DEPTH-1 is discarded, and slot p is loaded with din and marked occupied.
  - If no p exists (array full and din < val[DEPTH-1]): no change.
- clear = 1, din_valid = 0: all occ = 0 and all val = 0 next cycle.
- clear = 1, din_valid = 1: the array is flushed and din becomes the sole entry. Next cycle slot 0 = din and count = 1.
- din_valid = 0, clear = 0: the array holds.
- Empty slots rank below every value, including 0. A 0 sample therefore occupies a free slot.
- Comparison is unsigned, full-width.
- Read path: dout / dout_valid are a combinational mux of the registered array by rd_idx. There is no handshake; reads never alter state.

## Timing
- Update latency is 1 cycle. A sample accepted at edge N is visible on dout / count after edge N.
- One sample per cycle, sustained; there is no backpressure.
- reset asserted mid-stream: the state is fully cleared at that edge, regardless of din_valid or clear.
- count and full are registered, or derived only from occ; they have no combinational path from din.
- Critical path: DEPTH parallel comparators, then priority select, then shift mux. No pipelining; the target frequency assumes DEPTH <= 16 at DATA_WIDTH = 32.

## Configuration
- TOPK_TRACKER_UNIQUE_EN defined:
  - A valid sample equal to any occupied val[i] is dropped; the array, count and full are unchanged.
  - Ties therefore never create duplicate ranks.
  - Clear plus din together still loads din.
- Undefined:
  - Duplicates are inserted per the tie rule above.
  - No equality compare logic is generated.

## Structure
- Package topk_pkg:
  - function idx_w(depth) returning $clog2 with a minimum of 1.
  - function cnt_w(depth).
  - typedef for slot state {logic occ; logic [DATA_WIDTH-1:0] val} as a parametrised struct via the module's localparam.
- Sub-module topk_slot, one instance per rank. Each instance:
  - holds one slot register and computes its local "din wins here" compare;
  - selects among hold / load din / take from slot above, driven by the priority-select outputs.
- The top level owns the priority encoder, count, and read mux.

## Test plan
- Reset then stream 5, 9, 1, 7 (DEPTH = 4) -> ranks 0..3 = 9, 7, 5, 1; count = 4; full = 1.
- Full array 9, 7, 5, 1, then din = 3 -> 9, 7, 5, 3; then din = 0 -> unchanged.
- Partial fill with 4 only, then rd_idx = 2 -> dout = 0, dout_valid = 0; rd_idx = 0 -> 4, valid = 1.
- Array 8, 6, 6, 2, then din = 6:
  - without TOPK_TRACKER_UNIQUE_EN -> 8, 6, 6, 6;
  - with TOPK_TRACKER_UNIQUE_EN -> unchanged, count = 4.
- clear with din_valid, din = 11, on a full array -> next cycle slot 0 = 11, count = 1. Then reset asserted together with din_valid -> count = 0, dout = 0.
- Randomised 10k samples vs. a sort-based scoreboard, checking all ranks each cycle at DEPTH = 2, 5 and 16.

Source files
------------

// File: rtl/topk_pkg.sv
// Shared width helpers for the streaming top-K tracker.
package topk_pkg;

    // Index width for a rank selector; never collapses to zero bits.
    function automatic int idx_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Width able to hold an occupancy count of 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/topk_slot.sv
// One rank of the top-K array: holds a value and its occupancy, reports whether din
// would win this rank, and updates as hold / load din / take from the rank above.
module topk_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  above_occ,
    input  logic [DATA_WIDTH-1:0] above_val,
    output logic                  occ,
    output logic [DATA_WIDTH-1:0] val,
    output logic                  win
);

    logic                  occ_reg;
    logic [DATA_WIDTH-1:0] val_reg;

    // An empty rank loses to every sample, zero included; ties go to the new sample.
    assign win = !occ_reg || (din >= val_reg);
    assign occ = occ_reg;
    assign val = val_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_reg <= 1'b0;
            val_reg <= '0;
        end else if (flush) begin
            occ_reg <= load;
            val_reg <= load ? din : '0;
        end else if (load) begin
            occ_reg <= 1'b1;
            val_reg <= din;
        end else if (shift) begin
            occ_reg <= above_occ;
            val_reg <= above_val;
        end
    end

endmodule

// File: rtl/topk_tracker.sv
// Streaming top-K tracker: sorted descending array of the DEPTH largest samples.
// Optional TOPK_TRACKER_UNIQUE_EN drops samples equal to an occupied rank.
module topk_tracker
    import topk_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 4,
    localparam int IDX_W      = idx_w(DEPTH),
    localparam int CNT_W      = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  clear,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [CNT_W-1:0]      count,
    output logic                  full
);

    typedef struct packed {
        logic                  occ;
        logic [DATA_WIDTH-1:0] val;
    } slot_t;

    slot_t            slots [DEPTH];
    logic [DEPTH-1:0] win;
    logic [DEPTH-1:0] any_above;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] shift;
    logic             dup;
    logic             ins;

`ifdef TOPK_TRACKER_UNIQUE_EN
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slots[i].occ && (slots[i].val == din)) begin
                dup = 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign ins = din_valid & ~clear & ~dup;

    // The array is sorted with a contiguous occupied prefix, so win is monotonic and the
    // insertion point is simply the first winning rank; everything below it shifts down.
    always_comb begin
        any_above = '0;
        load      = '0;
        shift     = '0;
        for (int i = 1; i < DEPTH; i++) begin
            any_above[i] = any_above[i-1] | win[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            load[i]  = ins & win[i] & ~any_above[i];
            shift[i] = ins & any_above[i];
        end
        if (clear) begin
            load[0] = din_valid;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rank
            logic                  above_occ;
            logic [DATA_WIDTH-1:0] above_val;
            logic                  occ_w;
            logic [DATA_WIDTH-1:0] val_w;

            if (gi == 0) begin : g_head
                assign above_occ = 1'b0;
                assign above_val = '0;
            end else begin : g_body
                assign above_occ = slots[gi-1].occ;
                assign above_val = slots[gi-1].val;
            end

            topk_slot #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_slot (
                .clk       (clk),
                .reset     (reset),
                .flush     (clear),
                .load      (load[gi]),
                .shift     (shift[gi]),
                .din       (din),
                .above_occ (above_occ),
                .above_val (above_val),
                .occ       (occ_w),
                .val       (val_w),
                .win       (win[gi])
            );

            assign slots[gi] = '{occ: occ_w, val: val_w};
        end
    endgenerate

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(slots[i].occ);
        end
    end

    assign full = slots[DEPTH-1].occ;

    // Out-of-range indices match no rank and therefore read as empty.
    always_comb begin
        dout       = '0;
        dout_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((rd_idx == IDX_W'(i)) && slots[i].occ) begin
                dout       = slots[i].val;
                dout_valid = 1'b1;
            end
        end
    end

endmodule
